// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of digits processed per operation.
  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit_w);
    return width / digit_w;
  endfunction

  // Counter width that can hold 0..ndig.
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return (ndig + 1 <= 2) ? 1 : $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit ripple adder built from half-adder-pair full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_s,
  output logic               o_cout
);

  logic [DIGIT_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1       = i_a[i] ^ i_b[i];
    assign w_c1       = i_a[i] & i_b[i];
    assign o_s[i]     = w_s1 ^ w_c[i];
    assign w_c2       = w_s1 & w_c[i];
    assign w_c[i + 1] = w_c1 | w_c2;
  end

  assign o_cout = w_c[DIGIT_W];

endmodule

// File: rtl/serial_add_unit.sv
// Multi-cycle adder adding DIGIT_W bits per cycle with valid/ready on both sides.
// Optional subtract mode (port i_sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT_W);
  localparam int unsigned CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NDIG - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic             r_init;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [DIGIT_W-1:0] w_dsum;
  logic             w_dcout;
  logic [WIDTH-1:0] w_sum_shift;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; the carry out then reads as NOT borrow.
  assign w_b_in   = i_sub ? ~i_b : i_b;
  assign w_cin_in = i_sub ? 1'b1 : i_cin;
`else
  assign w_b_in   = i_b;
  assign w_cin_in = i_cin;
`endif

  digit_adder #(
    .DIGIT_W(DIGIT_W)
  ) u_digit_adder (
    .i_a   (r_a[DIGIT_W-1:0]),
    .i_b   (r_b[DIGIT_W-1:0]),
    .i_cin (r_carry),
    .o_s   (w_dsum),
    .o_cout(w_dcout)
  );

  if (NDIG == 1) begin : g_single
    assign w_sum_shift = w_dsum;
  end else begin : g_multi
    assign w_sum_shift = {w_dsum, r_sum[WIDTH-1:DIGIT_W]};
  end

  always_comb begin
    w_state_d  = r_state;
    o_in_ready = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // r_init keeps in_ready low until the first clock after reset release.
        o_in_ready = r_init;
        if (i_in_valid && r_init) begin
          w_accept  = 1'b1;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (r_cnt == LastCnt) w_state_d = StDone;
      end
      StDone: begin
        o_in_ready = i_out_ready;
        if (i_out_ready) begin
          w_accept  = i_in_valid;
          w_state_d = i_in_valid ? StRun : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_init  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_cnt   <= '0;
    end else if (r_state == StRun) begin
      r_a     <= r_a >> DIGIT_W;
      r_b     <= r_b >> DIGIT_W;
      r_sum   <= w_sum_shift;
      r_carry <= w_dcout;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state == StRun);
  assign o_sum       = r_sum;
  assign o_cout      = r_carry;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit (WIDTH=8 with DIGIT_W=2 and DIGIT_W=8).
module tb_serial_add_unit;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
  logic       sub8;
`endif

  logic       v8;
  logic       rdy8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c8;
  logic       ov8;
  logic       or8;
  logic [7:0] s8;
  logic       co8;
  logic       busy8;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_unit #(
    .WIDTH  (8),
    .DIGIT_W(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub      (sub),
`endif
    .i_in_valid (valid),
    .o_in_ready (in_ready),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_busy     (busy)
  );

  serial_add_unit #(
    .WIDTH  (8),
    .DIGIT_W(8)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub      (sub8),
`endif
    .i_in_valid (v8),
    .o_in_ready (rdy8),
    .i_a        (a8),
    .i_b        (b8),
    .i_cin      (c8),
    .o_out_valid(ov8),
    .i_out_ready(or8),
    .o_sum      (s8),
    .o_cout     (co8),
    .o_busy     (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; leaves the result in DONE unless release_it is set.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbo, input logic tcin,
                       input logic tsub, input logic [7:0] esum, input logic ecout,
                       input bit release_it, input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a     = ta;
    b     = tbo;
    cin   = tcin;
`ifdef SERIAL_ADD_SUB_EN
    sub   = tsub;
`endif
    valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
    cin   = ~tcin;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    int lat8;
    rst_n     = 1'b0;
    valid     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    v8        = 1'b0;
    a8        = '0;
    b8        = '0;
    c8        = 1'b0;
    or8       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub       = 1'b0;
    sub8      = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic adds and carry-out boundaries
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "t1");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t2a");
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "t2b");

    // Stall in DONE with a pending request that must not be taken
    do_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "t3");
    valid = 1'b1;
    a     = 8'h77;
    b     = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_sum", 32'(sum), 32'h47);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    check("t3_hold_cout", 32'(cout), 32'd0);
    valid     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_idle_valid", 32'(out_valid), 32'd0);
    check("t3_idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back operations with no idle cycle
    a         = 8'h01;
    b         = 8'h02;
    cin       = 1'b0;
    valid     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("t4_first_latency", 32'(n), 32'd5);
    check("t4_first_sum", 32'(sum), 32'h03);
    check("t4_first_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    n = 1;
    check("t4_no_bubble_busy", 32'(busy), 32'd1);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("t4_second_spacing", 32'(n), 32'd5);
    check("t4_second_sum", 32'(sum), 32'h30);
    check("t4_second_cout", 32'(cout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_idle_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the second RUN cycle
    a     = 8'h5A;
    b     = 8'h3C;
    cin   = 1'b0;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_sum", 32'(sum), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_after_in_ready", 32'(in_ready), 32'd1);
    check("t5_after_busy", 32'(busy), 32'd0);
    do_op(8'h21, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0, 1'b1, "t5_next");

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, "t6_sub_a");
    do_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, "t6_sub_b");
`endif

    // Single-digit configuration: one RUN cycle
    a8 = 8'hC8;
    b8 = 8'h64;
    c8 = 1'b0;
    v8 = 1'b1;
    check("t6_w8_in_ready", 32'(rdy8), 32'd1);
    @(posedge clk);
    lat8 = 1;
    @(negedge clk);
    v8 = 1'b0;
    a8 = 8'h00;
    while (!ov8 && lat8 < 40) begin
      @(posedge clk);
      lat8++;
      @(negedge clk);
    end
    check("t6_w8_latency", 32'(lat8), 32'd2);
    check("t6_w8_sum", 32'(s8), 32'h2C);
    check("t6_w8_cout", 32'(co8), 32'd1);
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check("t6_w8_released", 32'(ov8), 32'd0);
    check("t6_w8_busy", 32'(busy8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
